mem_arbiter: RTL

- Shares the single unified instruction/data memory between two requesters: the multicycle CPU controller and a debug/program-loader port.
- Each requester presents a held request (address, write enable, word/byte mode, write data). The block grants one requester, sequences the memory access over a fixed number of wait cycles, then returns a one-cycle ready pulse with read data.
- Sits between the CPU datapath's memory interface and the memory array.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 51 +++++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-interface constants: access modes, arbiter state encodings and requester indices.
// Mode constants are shared with the CPU controller's MemMode output.
package mem_pkg;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_SBYTE = 2'b01;
    localparam logic [1:0] MODE_UBYTE = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // The reserved encoding 2'b11 is treated as a word access.
    function automatic logic [1:0] fold_mode(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            MODE_SBYTE: r = MODE_SBYTE;
            MODE_UBYTE: r = MODE_UBYTE;
            default:    r = MODE_WORD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between the CPU and debug requesters.
// With MEM_ARB_FAIR_EN defined, a CPU-streak counter lets a waiting debug port in after MAX_CPU_STREAK CPU grants.
module mem_arb_pick #(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic grant_en,
    output logic pick_dbg
);

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = $clog2(MAX_CPU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          starved;

    assign starved  = (streak_q == STREAK_MAX);
    assign pick_dbg = dbg_req && (!cpu_req || starved);

    // Only CPU grants that bypass a waiting debug request extend the streak.
    always_comb begin
        streak_d = streak_q;
        if (grant_en) begin
            if (!pick_dbg && dbg_req) begin
                streak_d = starved ? streak_q : streak_q + 1'b1;
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_fair;

    assign unused_fair = clk ^ reset ^ grant_en ^ (MAX_CPU_STREAK > 0);
    assign pick_dbg    = dbg_req && !cpu_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: CPU controller vs debug/program-loader port.
// Define MEM_ARB_FAIR_EN to bound CPU starvation of the debug port (see mem_arb_pick).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int WAIT_CYCLES    = 1,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_mode,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [1:0]    dbg_mode,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner_dbg
);

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    arb_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          owner_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [1:0]    mode_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          busy_q;
    logic [1:0]    ready_q;
    logic [DW-1:0] rdata_q [2];

    logic          grant_en;
    logic          pick_dbg;
    logic          we_d;
    logic [1:0]    mode_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    assign grant_en = (state_q == ARB_IDLE) && (cpu_req || dbg_req);

    mem_arb_pick #(
        .MAX_CPU_STREAK (MAX_CPU_STREAK)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .grant_en (grant_en),
        .pick_dbg (pick_dbg)
    );

    always_comb begin
        we_d    = cpu_we;
        mode_d  = fold_mode(cpu_mode);
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        if (pick_dbg) begin
            we_d    = dbg_we;
            mode_d  = fold_mode(dbg_mode);
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
        end
    end

    // Memory-side fields come only from the grant-time latches, so requester changes mid-access are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ARB_IDLE;
            cnt_q            <= '0;
            owner_q          <= REQ_CPU;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            mode_q           <= MODE_WORD;
            addr_q           <= '0;
            wdata_q          <= '0;
            busy_q           <= 1'b0;
            ready_q          <= '0;
            rdata_q[REQ_CPU] <= '0;
            rdata_q[REQ_DBG] <= '0;
        end else begin
            ready_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_en) begin
                        owner_q  <= pick_dbg;
                        mem_en_q <= 1'b1;
                        mem_we_q <= we_d;
                        mode_q   <= mode_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        busy_q   <= 1'b1;
                        cnt_q    <= CNT_LOAD;
                        state_q  <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!mem_we_q) begin
                            rdata_q[owner_q] <= mem_rdata;
                        end
                        ready_q[owner_q] <= 1'b1;
                        mem_en_q         <= 1'b0;
                        mem_we_q         <= 1'b0;
                        state_q          <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ARB_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = ready_q[REQ_CPU];
    assign dbg_ready = ready_q[REQ_DBG];
    assign cpu_rdata = rdata_q[REQ_CPU];
    assign dbg_rdata = rdata_q[REQ_DBG];
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_mode  = mode_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner_dbg = owner_q;

endmodule
